// File: rtl/core_rms_pkg.sv
// Shared widths, default-configuration constants and compute FSM state type for the
// RMS scale block.
package core_rms_pkg;

  function automatic int unsigned calc_acc_w(int unsigned in_w, int unsigned max_len_log2);
    return 2 * in_w + max_len_log2;
  endfunction

  function automatic int unsigned calc_div_w(int unsigned rc_shift, int unsigned out_frac);
    return rc_shift + out_frac + 1;
  endfunction

  // Values for the default configuration (24-bit data, 24-bit scale, 16+8 shift).
  localparam int unsigned ACC_W = calc_acc_w(24, 8);
  localparam int unsigned DIV_W = calc_div_w(16, 8);
  localparam int unsigned SMAX  = (1 << 23) - 1;

  typedef enum logic [2:0] {
    StIdle,
    StMean,
    StSqrt,
    StDiv,
    StDone
  } rms_state_e;

endpackage

// File: rtl/core_rms_scale_if.sv
// Element stream in, scale/clear handshake out; slave is the scale generator.
interface core_rms_scale_if #(
  parameter int unsigned IN_DATA_WIDTH         = 24,
  parameter int unsigned RECOMPUTE_SCALE_WIDTH = 24,
  parameter int unsigned RECOMPUTE_SHIFT_WIDTH = 5,
  parameter int unsigned MAX_LEN_LOG2          = 8
);
  localparam int unsigned LenW = $clog2(MAX_LEN_LOG2 + 1);

  logic        [LenW-1:0]                  cfg_len_log2;
  logic signed [IN_DATA_WIDTH-1:0]         in_data;
  logic                                    in_data_vld;
  logic                                    rc_vec_done;
  logic signed [RECOMPUTE_SCALE_WIDTH-1:0] rc_scale;
  logic                                    rc_scale_vld;
  logic                                    rc_scale_clear;
  logic        [RECOMPUTE_SHIFT_WIDTH-1:0] rms_rc_shift;

  modport master (
    output cfg_len_log2, in_data, in_data_vld, rc_vec_done,
    input  rc_scale, rc_scale_vld, rc_scale_clear, rms_rc_shift
  );

  modport slave (
    input  cfg_len_log2, in_data, in_data_vld, rc_vec_done,
    output rc_scale, rc_scale_vld, rc_scale_clear, rms_rc_shift
  );
endinterface

// File: rtl/rms_isqrt_seq.sv
// Restoring bit-serial integer square root, one root bit per cycle.
// done is high during the final step; root is valid from the following cycle.
module rms_isqrt_seq #(
  parameter int unsigned W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*W-1:0]   radicand,
  output logic             done,
  output logic [W-1:0]     root
);
  localparam int unsigned RemW = W + 2;
  localparam int unsigned CntW = $clog2(W + 1);

  logic [2*W-1:0]  x_q;
  logic [RemW-1:0] rem_q, rem_sh, trial;
  logic [W-1:0]    root_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic            ge;

  always_comb begin
    rem_sh = (rem_q << 2) | RemW'(x_q[2*W-1 -: 2]);
    trial  = {root_q, 2'b01};
    ge     = rem_sh >= trial;
  end

  assign done = run_q && (cnt_q == CntW'(1));
  assign root = root_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      x_q    <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CntW'(W);
      run_q  <= 1'b1;
    end else if (run_q) begin
      x_q    <= x_q << 2;
      rem_q  <= ge ? (rem_sh - trial) : rem_sh;
      root_q <= {root_q[W-2:0], ge};
      cnt_q  <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/core_rms_scale.sv
// Per-vector sum of squares -> floor(2^(RC_SHIFT+OUT_FRAC_BITS) / isqrt(mean+EPS)),
// with one pending scale held until the consumer finishes the vector in flight.
module core_rms_scale
  import core_rms_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH         = 24,
  parameter int unsigned RECOMPUTE_SCALE_WIDTH = 24,
  parameter int unsigned RECOMPUTE_SHIFT_WIDTH = 5,
  parameter int unsigned RC_SHIFT              = 16,
  parameter int unsigned OUT_FRAC_BITS         = 8,
  parameter int unsigned MAX_LEN_LOG2          = 8,
  parameter int unsigned EPS                   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  core_rms_scale_if.slave bus,
  output logic            busy,
  output logic            error
);
  localparam int unsigned SqW     = 2 * IN_DATA_WIDTH;
  localparam int unsigned AccW    = calc_acc_w(IN_DATA_WIDTH, MAX_LEN_LOG2);
  localparam int unsigned DivW    = calc_div_w(RC_SHIFT, OUT_FRAC_BITS);
  localparam int unsigned LenW    = $clog2(MAX_LEN_LOG2 + 1);
  localparam int unsigned CntW    = MAX_LEN_LOG2 + 1;
  localparam int unsigned DivCntW = $clog2(DivW);
  localparam int unsigned RemW    = IN_DATA_WIDTH + 1;
  localparam logic [RECOMPUTE_SCALE_WIDTH-1:0] SMax =
      {1'b0, {(RECOMPUTE_SCALE_WIDTH-1){1'b1}}};

  rms_state_e state_q, state_d;

  // Accumulator
  logic signed [SqW-1:0] din_ext;
  logic [SqW-1:0]        sq;
  logic [AccW-1:0]       acc_q, acc_sum;
  logic [CntW-1:0]       cnt_q, last_idx;
  logic [LenW-1:0]       len_q, len_cur, cfg_len;
  logic                  is_last, snap_take, snap_drop;

  assign din_ext  = SqW'(bus.in_data);
  assign sq       = din_ext * din_ext;
  assign acc_sum  = acc_q + AccW'(sq);
  assign cfg_len  = (bus.cfg_len_log2 > LenW'(MAX_LEN_LOG2)) ? LenW'(MAX_LEN_LOG2)
                                                             : bus.cfg_len_log2;
  assign len_cur  = (cnt_q == '0) ? cfg_len : len_q;
  assign last_idx = (CntW'(1) << len_cur) - CntW'(1);
  assign is_last  = bus.in_data_vld && (cnt_q == last_idx);
  assign snap_take = is_last && (state_q == StIdle);
  assign snap_drop = is_last && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (bus.in_data_vld) begin
      len_q <= len_cur;
      if (is_last) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Mean and square root
  logic [AccW-1:0] snap_q;
  logic [LenW-1:0] snap_len_q;
  logic [AccW:0]   mean_wide;
  logic [SqW-1:0]  mean_sat;
  logic [IN_DATA_WIDTH-1:0] root;
  logic            sqrt_done;

  assign mean_wide = {1'b0, snap_q >> snap_len_q} + (AccW+1)'(EPS);
  assign mean_sat  = (mean_wide > (AccW+1)'({SqW{1'b1}})) ? {SqW{1'b1}} : mean_wide[SqW-1:0];

  rms_isqrt_seq #(
    .W(IN_DATA_WIDTH)
  ) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state_q == StMean),
    .radicand (mean_sat),
    .done     (sqrt_done),
    .root     (root)
  );

  // Restoring divider of the constant 2^(DivW-1) by root
  logic [RemW-1:0]    div_rem_q, rem_sh, rem_nx;
  logic [DivW-1:0]    div_quo_q;
  logic [DivCntW-1:0] div_cnt_q;
  logic               div_bit, div_ge;
  logic [RECOMPUTE_SCALE_WIDTH-1:0] result;

  assign div_bit = (div_cnt_q == DivCntW'(DivW - 1));
  assign rem_sh  = (div_rem_q << 1) | RemW'(div_bit);
  assign div_ge  = rem_sh >= RemW'(root);
  assign rem_nx  = div_ge ? (rem_sh - RemW'(root)) : rem_sh;
  assign result  = ((root == '0) || (64'(div_quo_q) > 64'(SMax)))
                   ? SMax : RECOMPUTE_SCALE_WIDTH'(div_quo_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (snap_take) state_d = StMean;
      StMean:  state_d = StSqrt;
      StSqrt:  if (sqrt_done) state_d = StDiv;
      StDiv:   if (div_cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      snap_len_q <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (snap_take) begin
        snap_q     <= acc_sum;
        snap_len_q <= len_cur;
      end
      if (state_q == StSqrt && sqrt_done) begin
        div_rem_q <= '0;
        div_quo_q <= '0;
        div_cnt_q <= DivCntW'(DivW - 1);
      end else if (state_q == StDiv) begin
        div_rem_q <= rem_nx;
        div_quo_q <= {div_quo_q[DivW-2:0], div_ge};
        div_cnt_q <= div_cnt_q - DivCntW'(1);
      end
    end
  end

  // Issue / pending handling
  logic [RECOMPUTE_SCALE_WIDTH-1:0] scale_q, scale_d, pend_val_q, pend_val_d;
  logic vld_q, vld_d, clr_q, clr_d, pend_q, pend_d, in_use_q, in_use_d, error_q, error_d;
  logic done_ev, vec_done;

  assign done_ev  = (state_q == StDone);
  assign vec_done = bus.rc_vec_done && in_use_q;

  always_comb begin
    scale_d    = scale_q;
    vld_d      = 1'b0;
    clr_d      = 1'b0;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    in_use_d   = in_use_q;
    error_d    = error_q | snap_drop;
    if (!in_use_q) begin
      if (done_ev) begin
        scale_d  = result;
        vld_d    = 1'b1;
        in_use_d = 1'b1;
      end
    end else if (vec_done) begin
      // Older pending result goes out first; a coincident DONE takes its slot.
      if (pend_q) begin
        scale_d    = pend_val_q;
        vld_d      = 1'b1;
        pend_d     = done_ev;
        pend_val_d = result;
      end else if (done_ev) begin
        scale_d = result;
        vld_d   = 1'b1;
      end else begin
        clr_d    = 1'b1;
        in_use_d = 1'b0;
      end
    end else if (done_ev) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q    <= '0;
      vld_q      <= 1'b0;
      clr_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      in_use_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      scale_q    <= scale_d;
      vld_q      <= vld_d;
      clr_q      <= clr_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      in_use_q   <= in_use_d;
      error_q    <= error_d;
    end
  end

  assign bus.rc_scale       = scale_q;
  assign bus.rc_scale_vld   = vld_q;
  assign bus.rc_scale_clear = clr_q;
  assign bus.rms_rc_shift   = RECOMPUTE_SHIFT_WIDTH'(RC_SHIFT);
  assign busy               = (state_q != StIdle);
  assign error              = error_q;

endmodule

// File: tb/tb_core_rms_scale.sv
// Bench for core_rms_scale: directed scenarios plus random element streams, all checked
// every cycle against a cycle-level behavioural model of the scale/clear protocol.
module tb_core_rms_scale;
  import core_rms_pkg::*;

  localparam int IN_W = 24;
  localparam int MAXL = 8;
  localparam int LAT  = IN_W + int'(DIV_W) + 2;
  localparam longint SMX = longint'(SMAX);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, error;
  always #5 clk = ~clk;

  core_rms_scale_if #(
    .IN_DATA_WIDTH(IN_W), .RECOMPUTE_SCALE_WIDTH(24), .RECOMPUTE_SHIFT_WIDTH(5),
    .MAX_LEN_LOG2(MAXL)
  ) ifc ();

  core_rms_scale #(
    .IN_DATA_WIDTH(IN_W), .RECOMPUTE_SCALE_WIDTH(24), .RECOMPUTE_SHIFT_WIDTH(5),
    .RC_SHIFT(16), .OUT_FRAC_BITS(8), .MAX_LEN_LOG2(MAXL), .EPS(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc),
    .busy  (busy),
    .error (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor(2^24 / floor(sqrt(sumsq >> len))), saturated to SMAX.
  function automatic longint ref_scale(longint sumsq, int len);
    longint m, r, q;
    m = sumsq >> len;
    r = longint'($sqrt(real'(m)));
    while (r * r > m) r--;
    while ((r + 1) * (r + 1) <= m) r++;
    if (r == 0) return SMX;
    q = (longint'(1) << 24) / r;
    return (q > SMX) ? SMX : q;
  endfunction

  // Behavioural model, stepped on every rising edge.
  int     cyc = 0;
  longint m_acc, m_sched_val, m_pend_val, e_scale;
  int     m_cnt, m_len, m_sched_at, m_busy_end;
  bit     m_sched, m_pend, m_inuse, m_err, e_vld, e_clr, e_busy;
  bit     chk_en = 1'b0;

  always @(posedge clk) begin
    longint x, res;
    bit done_now, vd;
    cyc++;
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_len = 0; m_sched = 0; m_busy_end = 0;
      m_pend = 0; m_inuse = 0; m_err = 0;
      e_vld = 0; e_clr = 0; e_busy = 0; e_scale = 0;
    end else begin
      e_vld = 0;
      e_clr = 0;
      done_now = m_sched && (cyc == m_sched_at);
      res = m_sched_val;
      if (done_now) m_sched = 0;
      vd = ifc.rc_vec_done && m_inuse;
      if (!m_inuse) begin
        if (done_now) begin e_scale = res; e_vld = 1; m_inuse = 1; end
      end else if (vd) begin
        if (m_pend) begin
          e_scale = m_pend_val; e_vld = 1; m_pend = done_now; m_pend_val = res;
        end else if (done_now) begin
          e_scale = res; e_vld = 1;
        end else begin
          e_clr = 1; m_inuse = 0;
        end
      end else if (done_now) begin
        if (m_pend) m_err = 1;
        else begin m_pend = 1; m_pend_val = res; end
      end
      if (ifc.in_data_vld) begin
        if (m_cnt == 0) m_len = (int'(ifc.cfg_len_log2) > MAXL) ? MAXL : int'(ifc.cfg_len_log2);
        x = ifc.in_data;
        m_acc += x * x;
        m_cnt++;
        if (m_cnt == (1 << m_len)) begin
          if (cyc > m_busy_end) begin
            m_sched = 1; m_sched_at = cyc + LAT; m_busy_end = cyc + LAT;
            m_sched_val = ref_scale(m_acc, m_len);
          end else begin
            m_err = 1;
          end
          m_acc = 0;
          m_cnt = 0;
        end
      end
      e_busy = (cyc < m_busy_end);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("rc_scale_vld", 64'(ifc.rc_scale_vld), 64'(e_vld));
      check("rc_scale_clear", 64'(ifc.rc_scale_clear), 64'(e_clr));
      check("rc_scale", 64'(ifc.rc_scale), 64'(e_scale));
      check("error", 64'(error), 64'(m_err));
      check("busy", 64'(busy), 64'(e_busy));
      check("rms_rc_shift", 64'(ifc.rms_rc_shift), 64'd16);
    end
  end

  task automatic drive(bit v, longint d, int len, bit vd);
    @(negedge clk);
    #1;
    ifc.in_data_vld  = v;
    ifc.in_data      = IN_W'(d);
    ifc.cfg_len_log2 = 4'(len);
    ifc.rc_vec_done  = vd;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 2, 0);
  endtask

  task automatic send4(longint a, longint b, longint c, longint d);
    drive(1, a, 2, 0);
    drive(1, b, 2, 0);
    drive(1, c, 2, 0);
    drive(1, d, 2, 0);
  endtask

  // Pulse rc_vec_done and check the response registered on that edge.
  task automatic vec_done(string nm, bit exp_clr, longint exp_scale);
    drive(0, 0, 2, 1);
    drive(0, 0, 2, 0);
    check({nm, "_vld"}, 64'(ifc.rc_scale_vld), 64'(!exp_clr));
    check({nm, "_clear"}, 64'(ifc.rc_scale_clear), 64'(exp_clr));
    if (!exp_clr) check({nm, "_scale"}, 64'(ifc.rc_scale), 64'(exp_scale));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    bit found;
    logic signed [IN_W-1:0] r24;
    ifc.in_data_vld = 0; ifc.in_data = '0; ifc.cfg_len_log2 = 4'd2; ifc.rc_vec_done = 0;
    repeat (3) @(negedge clk);
    check("rst_scale", 64'(ifc.rc_scale), 64'd0);
    check("rst_vld", 64'(ifc.rc_scale_vld), 64'd0);
    check("rst_clear", 64'(ifc.rc_scale_clear), 64'd0);
    check("rst_shift", 64'(ifc.rms_rc_shift), 64'd16);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("ref_3333", 64'(ref_scale(36, 2)), 64'd5592405);
    check("ref_10_14", 64'(ref_scale(496, 2)), 64'd1525201);
    check("ref_pm4", 64'(ref_scale(64, 2)), 64'd4194304);
    check("ref_ones", 64'(ref_scale(4, 2)), 64'd8388607);
    check("ref_zero", 64'(ref_scale(0, 2)), 64'd8388607);

    // Latency and value of the first scale.
    send4(3, 3, 3, 3);
    found = 0;
    lat   = -1;
    for (int i = 0; i < 100 && !found; i++) begin
      drive(0, 0, 2, 0);
      if (ifc.rc_scale_vld) begin found = 1; lat = i; end
    end
    check("latency", 64'(lat), 64'(LAT));
    check("first_scale", 64'(ifc.rc_scale), 64'd5592405);

    send4(10, 10, 10, 14);  idle(60); vec_done("mean124", 0, 1525201);
    send4(-4, 4, -4, 4);    idle(60); vec_done("signed_sq", 0, 4194304);
    send4(1, 1, 1, 1);      idle(60); vec_done("sat_ones", 0, 8388607);
    send4(0, 0, 0, 0);      idle(60); vec_done("sat_zero", 0, 8388607);
    vec_done("clear1", 1, 0);

    // A issued directly, B held until the consumer finishes A.
    send4(100, 100, 100, 100); idle(60);
    send4(50, 50, 50, 50);     idle(60);
    vec_done("held_b", 0, 335544);
    vec_done("clear2", 1, 0);

    // Third result while one is pending is dropped.
    send4(100, 100, 100, 100); idle(55);
    send4(50, 50, 50, 50);     idle(55);
    send4(3, 3, 3, 3);         idle(60);
    check("err_pending_full", 64'(error), 64'd1);
    vec_done("held_b2", 0, 335544);
    vec_done("clear3", 1, 0);

    // Vectors closer together than LAT overrun the compute FSM.
    do_reset();
    send4(3, 3, 3, 3); idle(5);
    send4(10, 10, 10, 14); idle(60);
    check("err_overrun", 64'(error), 64'd1);
    check("overrun_first", 64'(ifc.rc_scale), 64'd5592405);

    // Reset while the square root is running.
    send4(100, 100, 100, 100); idle(8);
    check("busy_mid_sqrt", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_scale", 64'(ifc.rc_scale), 64'd0);
    check("arst_vld", 64'(ifc.rc_scale_vld), 64'd0);
    check("arst_clear", 64'(ifc.rc_scale_clear), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_shift", 64'(ifc.rms_rc_shift), 64'd16);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    send4(3, 3, 3, 3); idle(60);
    check("after_reset_scale", 64'(ifc.rc_scale), 64'd5592405);

    // Random streams at three densities; cfg_len_log2 varies every cycle.
    for (int p = 0; p < 3; p++) begin
      int dens;
      dens = (p == 0) ? 3 : ((p == 1) ? 12 : 30);
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        bit v, vd;
        v  = ($urandom_range(0, dens) == 0);
        vd = ($urandom_range(0, 30) == 0);
        r24 = $urandom;
        if ($urandom_range(0, 3) == 0) r24 = IN_W'($signed($urandom_range(0, 40)) - 20);
        drive(v, longint'(r24), $urandom_range(0, 4), vd);
      end
      idle(80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
